// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources.
// Optional transmitter-response timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned TIMEOUT = 4096,
  localparam int unsigned GNT_W  = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic [GNT_W-1:0]          grant_id,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_wr,
  input  logic                      tx_busy,
  output logic                      arb_busy,
  output logic                      err_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [GNT_W-1:0]    last_grant;
  logic [GNT_W-1:0]    sel;
  logic                sel_vld;
  logic [DATA_W-1:0]   sel_data;
  logic                grant_fire;
  logic                done_fire;
  logic                tmo_fire;
  logic                tmo_hit;

  // First valid requester after last_grant, wrapping modulo NUM_REQ
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!sel_vld && req_valid[j] &&
            (32'(j) == (32'(last_grant) + i) % NUM_REQ)) begin
          sel     = GNT_W'(j);
          sel_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel == GNT_W'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    tx_wr      = 1'b0;
    arb_busy   = (state != IDLE);
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    tmo_fire   = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && sel_vld) begin
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (sel == GNT_W'(i));
          end
          grant_fire = 1'b1;
          state_nxt  = START;
        end
      end
      START: begin
        tx_wr     = 1'b1;
        state_nxt = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_nxt = WAIT_DONE;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      WAIT_DONE: begin
        // A normal completion wins over a coincident timeout
        if (!tx_busy) begin
          done_fire = 1'b1;
          state_nxt = IDLE;
        end else if (tmo_hit) begin
          tmo_fire  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_data    <= '0;
      grant_id   <= '0;
      last_grant <= GNT_W'(NUM_REQ - 1);
      req_done   <= '0;
    end else begin
      req_done <= '0;
      if (grant_fire) begin
        tx_data  <= sel_data;
        grant_id <= sel;
      end
      if (done_fire) begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
          req_done[i] <= (grant_id == GNT_W'(i));
        end
      end
      if (done_fire || tmo_fire) begin
        last_grant <= grant_id;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts cycles spent waiting on the transmitter; cleared while entering WAIT_BUSY
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt     <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= tmo_fire;
      if (state == START) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_BUSY || state == WAIT_DONE) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
    end
  end

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (2 requesters, 8-bit data).
module tb_uart_tx_arbiter;

  logic        clk_tb;
  logic        reset;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;
  logic [0:0]  grant_id;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_busy;
  logic        arb_busy;
  logic        err_timeout;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .DATA_W  (8),
    .NUM_REQ (2),
    .TIMEOUT (16)
  ) dut (
    .clk         (clk_tb),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .req_done    (req_done),
    .grant_id    (grant_id),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_busy     (tx_busy),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout)
  );

  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    tx_busy   = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  // Full transfer starting in an IDLE cycle with requests already presented
  task automatic xfer(input int id, input logic [7:0] d, input bit corrupt);
    #1;
    check("ready_grant", 32'(req_ready), 32'(1) << id);
    step();
    check("tx_wr_start", 32'(tx_wr), 32'd1);
    check("tx_data_start", 32'(tx_data), 32'(d));
    check("grant_id", 32'(grant_id), 32'(id));
    check("ready_start", 32'(req_ready), 32'd0);
    if (corrupt) req_data[7:0] = 8'hFF;
    step();
    check("tx_wr_wait_busy", 32'(tx_wr), 32'd0);
    tx_busy = 1'b1;
    step();
    step();
    check("ready_wait_done", 32'(req_ready), 32'd0);
    check("tx_wr_wait_done", 32'(tx_wr), 32'd0);
    check("tx_data_hold", 32'(tx_data), 32'(d));
    check("done_early", 32'(req_done), 32'd0);
    tx_busy = 1'b0;
    step();
    check("req_done", 32'(req_done), 32'(1) << id);
    check("arb_idle", 32'(arb_busy), 32'd0);
    check("err_timeout", 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 2'b00;
    req_data  = 16'h0000;
    tx_busy   = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_done", 32'(req_done), 32'd0);
    check("rst_tx_wr", 32'(tx_wr), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_err_timeout", 32'(err_timeout), 32'd0);
    step();
    reset = 1'b1;
    step();

    // Single source
    req_valid = 2'b01;
    req_data  = 16'h00A1;
    xfer(0, 8'hA1, 1'b0);
    req_valid = 2'b00;
    step();
    check("done_one_cycle", 32'(req_done), 32'd0);
    check("idle_no_ready", 32'(req_ready), 32'd0);

    // Contention: strict alternation
    do_reset();
    req_valid = 2'b11;
    req_data  = 16'h94A1;
    xfer(0, 8'hA1, 1'b0);
    xfer(1, 8'h94, 1'b0);
    xfer(0, 8'hA1, 1'b0);
    xfer(1, 8'h94, 1'b0);
    req_valid = 2'b00;

    // Busy transmitter holds off grants in IDLE
    do_reset();
    tx_busy   = 1'b1;
    req_valid = 2'b10;
    req_data  = 16'h5C00;
    for (int k = 0; k < 3; k++) begin
      check("busy_no_ready", 32'(req_ready), 32'd0);
      step();
      check("busy_idle", 32'(arb_busy), 32'd0);
    end
    tx_busy = 1'b0;
    xfer(1, 8'h5C, 1'b0);
    req_valid = 2'b00;

    // Mid-transfer reset in WAIT_DONE
    do_reset();
    req_valid = 2'b11;
    req_data  = 16'h94A1;
    step();
    step();
    tx_busy = 1'b1;
    step();
    step();
    check("pre_rst_busy", 32'(arb_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_arb_busy", 32'(arb_busy), 32'd0);
    check("mid_rst_tx_data", 32'(tx_data), 32'd0);
    check("mid_rst_tx_wr", 32'(tx_wr), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant_id", 32'(grant_id), 32'd0);
    tx_busy = 1'b0;
    step();
    check("mid_rst_no_done", 32'(req_done), 32'd0);
    reset = 1'b1;
    xfer(0, 8'hA1, 1'b0);
    req_valid = 2'b00;

    // Data stability after handshake
    do_reset();
    req_valid = 2'b01;
    req_data  = 16'h0094;
    xfer(0, 8'h94, 1'b1);
    req_valid = 2'b00;
    step();

`ifdef UART_ARB_TIMEOUT_EN
    // Transmitter never responds
    do_reset();
    req_valid = 2'b01;
    req_data  = 16'h94A1;
    #1;
    check("to_ready", 32'(req_ready), 32'd1);
    step();
    check("to_tx_wr", 32'(tx_wr), 32'd1);
    req_valid = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      step();
      check("to_early", 32'(err_timeout), 32'd0);
    end
    step();
    check("to_pulse", 32'(err_timeout), 32'd1);
    check("to_no_done", 32'(req_done), 32'd0);
    check("to_idle", 32'(arb_busy), 32'd0);
    check("to_next_ready", 32'(req_ready), 32'd2);
    step();
    check("to_pulse_end", 32'(err_timeout), 32'd0);
    check("to_next_grant", 32'(grant_id), 32'd1);
    req_valid = 2'b00;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte sources, e.g. the host write path and a status/echo source.
- Accepts one byte per valid/ready handshake, chosen round-robin.
- Presents the byte to the transmitter with a one-cycle write strobe, then holds off further grants until the transmitter's busy flag has risen and fallen.
- Sits between the requesters and the UART transmitter, on the same clock domain.

Parameters:
- DATA_W, 8: byte width on requester and transmitter sides.
- NUM_REQ, 2: number of requesters; legal range 2..4.
- TIMEOUT, 4096: cycle limit for transmitter response; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- req_valid  in  NUM_REQ  requester i has a byte to send.
- req_data  in  NUM_REQ*DATA_W  byte of requester i in bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot; byte of requester i is accepted this cycle.
- req_done  out  NUM_REQ  one-cycle pulse; byte of requester i fully transmitted.
- grant_id  out  clog2(NUM_REQ)  index of the current or last granted requester.
- tx_data  out  DATA_W  byte to the transmitter; stable from accept until done.
- tx_wr  out  1  one-cycle write strobe to the transmitter.
- tx_busy  in  1  transmitter busy flag.
- arb_busy  out  1  high in every state except IDLE.
- err_timeout  out  1  one-cycle pulse on transmitter timeout; tied 0 without the macro.

Behaviour:
- Reset values: state=IDLE, req_ready=0, req_done=0, tx_wr=0, tx_data=0, arb_busy=0, err_timeout=0, grant_id=0.
- Reset sets the internal pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, with tx_busy=0 and at least one req_valid set:
  - Select the first valid requester scanning last_grant+1, last_grant+2, ... with modulo-NUM_REQ wrap.
  - req_ready[sel]=1 combinationally in the same cycle.
  - On that edge: tx_data<=req_data[sel], grant_id<=sel, state->START.
- IDLE with tx_busy=1: no grant, req_ready all 0. This covers a transmitter still busy from a prior or foreign write.
- START:
  - tx_wr=1 for exactly one cycle, decoded from the state register, so glitch-free.
  - Next state is WAIT_BUSY.
  - Latency: handshake at cycle N gives tx_wr at cycle N+1.
- WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE.
- WAIT_DONE: stay until tx_busy=0. On that edge:
  - req_done[grant_id] pulses for one cycle.
  - last_grant<=grant_id.
  - state->IDLE.
- Earliest next grant is the cycle after the done pulse. Minimum spacing between two tx_wr strobes is 4 cycles plus transmitter busy time.
- req_ready is never asserted outside IDLE. At most one bit of req_ready is set per cycle.
- A requester that drops req_valid before seeing req_ready loses nothing and commits nothing.
- A requester whose req_valid stays high after its done pulse is re-eligible. It is served only after every other valid requester has had a turn.
- Simultaneous requests: round-robin order only. With all requesters valid continuously, grants go 0,1,..,NUM_REQ-1,0,...
- Changes to req_data after the handshake do not affect tx_data.
- tx_busy falling in the same cycle it rose, or glitching in WAIT_BUSY, is not tracked. Only the rise-then-fall sequence across states completes a transfer.
- Reset asserted mid-transfer:
  - All outputs return to reset values asynchronously and last_grant returns to NUM_REQ-1.
  - The in-flight byte is dropped with no done pulse.
  - Handling of the partly sent frame belongs to the transmitter.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT_BUSY and counts every cycle spent in WAIT_BUSY and WAIT_DONE.
  - When the count reaches TIMEOUT, err_timeout pulses for one cycle, no req_done is issued, last_grant<=grant_id and state->IDLE.
  - The dropped byte is not retried.
- Without the macro: no counter, WAIT_BUSY and WAIT_DONE wait indefinitely, err_timeout is constant 0.

Test Plan:
- Single source: reset, release; req_valid[0]=1 with data 8'hA1. Expect req_ready[0] the same cycle, tx_wr the next cycle with tx_data=8'hA1, then req_done[0] one cycle after tx_busy falls.
- Contention: req_valid=2'b11 with data 8'hA1 and 8'h94, held. Expect grants in order 0,1,0,1. Expect no second tx_wr before the first tx_busy fall.
- Busy transmitter: tx_busy=1 while in IDLE with req_valid[1]=1. Expect no req_ready until tx_busy=0, then a grant to requester 1.
- Mid-transfer reset: drop reset to 0 while in WAIT_DONE. Expect all outputs 0 immediately and no req_done. After release, a request from requester 1 with both valid still grants requester 0 first.
- Data stability: change req_data[7:0] to 8'hFF one cycle after accepting 8'h94. Expect tx_data to stay 8'h94 until done.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT=16): after tx_wr, hold tx_busy=0. Expect err_timeout after 16 cycles, return to IDLE, no req_done, next grant to the other requester.
